// File: rtl/pistorm_pkg.sv
// Shared register map, control bit positions and queue entry type for the
// Pi-side transaction queue.
package pistorm_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_ADDR_LO = 2'd1;
    localparam logic [1:0] REG_ADDR_HI = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int SIZE_BIT = 8;
    localparam int RW_BIT   = 9;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
        logic        rw;
        logic        uds_n;
        logic        lds_n;
    } txn_t;

    localparam txn_t TXN_IDLE = '{addr: 24'h0, data: 16'h0, rw: 1'b0, uds_n: 1'b1, lds_n: 1'b1};

    // ctrl is the low ten bits of the ADDR_HI write: address bits, size and direction.
    function automatic txn_t build_txn(input logic [9:0]  ctrl,
                                       input logic [15:0] lo,
                                       input logic [15:0] data,
                                       input logic        a0);
        txn_t t;
        t.addr = {ctrl[7:0], lo};
        t.data = data;
        t.rw   = ctrl[RW_BIT];
        if (ctrl[SIZE_BIT]) begin
            t.uds_n = a0;
            t.lds_n = ~a0;
        end else begin
            t.uds_n = 1'b0;
            t.lds_n = 1'b0;
        end
        return t;
    endfunction

endpackage

// File: rtl/pistorm_txn_queue_if.sv
// Handshake between the transaction queue (master) and the 68K bus engine (slave).
interface pistorm_txn_queue_if #(
    parameter int AW = 24,
    parameter int DW = 16
);
    logic          op_valid;
    logic          op_ready;
    logic [AW-1:0] op_addr;
    logic [DW-1:0] op_data;
    logic          op_rw;
    logic          op_uds_n;
    logic          op_lds_n;
    logic          op_done;
    logic [DW-1:0] op_rdata;

    modport master (
        output op_valid, op_addr, op_data, op_rw, op_uds_n, op_lds_n,
        input  op_ready, op_done, op_rdata
    );

    modport slave (
        input  op_valid, op_addr, op_data, op_rw, op_uds_n, op_lds_n,
        output op_ready, op_done, op_rdata
    );
endinterface

// File: rtl/pistorm_sync_fifo.sv
// In-order DEPTH x txn_t queue; also exposes the head and fill level as they
// will be after the current edge so the owner can register its outputs.
module pistorm_sync_fifo
    import pistorm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  txn_t                  din,
    output txn_t                  head_next,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] level,
    output logic [$clog2(DEPTH):0] level_next
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CAP = (PW+1)'(DEPTH);

    txn_t          mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr_nxt;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == CAP);
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // A push landing on the slot that becomes head must bypass the memory.
    always_comb begin
        rd_ptr_nxt = pop_ok ? rd_ptr + PW'(1) : rd_ptr;
        level_next = level;
        case ({push_ok, pop_ok})
            2'b10:   level_next = level + (PW+1)'(1);
            2'b01:   level_next = level - (PW+1)'(1);
            default: level_next = level;
        endcase
        head_next = (push_ok && (wr_ptr == rd_ptr_nxt)) ? din : mem[rd_ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            level  <= level_next;
        end
    end

endmodule

// File: rtl/pistorm_txn_queue.sv
// Pi-side transaction assembler and posted-write queue feeding the 68K bus engine.
// Build option POSTED_WRITE_EN: busy only on full queue or pending read; otherwise legacy busy.
module pistorm_txn_queue
    import pistorm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 24,
    parameter int DW    = 16
) (
    input  logic                   c200m,
    input  logic                   rst,
    input  logic                   pi_wr_stb,
    input  logic [1:0]             pi_reg,
    input  logic [DW-1:0]          pi_wdata,
    pistorm_txn_queue_if.master    op,
    output logic [DW-1:0]          rd_data,
    output logic                   rd_valid,
    output logic                   txn_busy,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);
    localparam int LW  = $clog2(DEPTH) + 1;
    localparam int RCW = $clog2(DEPTH + 2);

    logic [DW-1:0]  data_stage;
    logic [DW-1:0]  addr_lo;
    logic           a0;
    logic           commit;
    logic           pop;
    logic           full;
    logic           empty;
    logic           push_ok;
    logic           read_push;
    logic           done_ok;
    logic           read_done;
    logic           outstanding;
    logic           outstanding_nxt;
    logic           inflight_rw;
    logic           valid_nxt;
    logic           busy_nxt;
    logic           op_valid_q;
    txn_t           new_txn;
    txn_t           head_next;
    txn_t           op_q;
    logic [LW-1:0]  level_nxt;
    logic [RCW-1:0] read_cnt;
    logic [RCW-1:0] read_cnt_nxt;

    assign commit    = pi_wr_stb && (pi_reg == REG_ADDR_HI);
    assign new_txn   = build_txn(pi_wdata[9:0], addr_lo, data_stage, a0);
    assign pop       = op_valid_q && op.op_ready && !empty;
    assign push_ok   = commit && (!full || pop);
    assign read_push = push_ok && new_txn.rw;
    assign done_ok   = op.op_done && outstanding;
    assign read_done = done_ok && inflight_rw;

    assign op.op_valid = op_valid_q;
    assign op.op_addr  = AW'(op_q.addr);
    assign op.op_data  = op_q.data;
    assign op.op_rw    = op_q.rw;
    assign op.op_uds_n = op_q.uds_n;
    assign op.op_lds_n = op_q.lds_n;

    pistorm_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (c200m),
        .rst        (rst),
        .push       (commit),
        .pop        (pop),
        .din        (new_txn),
        .head_next  (head_next),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .level_next (level_nxt)
    );

    always_ff @(posedge c200m) begin
        if (rst) begin
            data_stage <= '0;
            addr_lo    <= '0;
            a0         <= 1'b0;
        end else if (pi_wr_stb) begin
            case (pi_reg)
                REG_DATA:    data_stage <= pi_wdata;
                REG_ADDR_LO: begin
                    addr_lo <= pi_wdata;
                    a0      <= pi_wdata[0];
                end
                REG_ADDR_HI, REG_STATUS: ;
            endcase
        end
    end

    // Reads are counted rather than flagged so a read queued behind another keeps busy asserted.
    always_comb begin
        outstanding_nxt = outstanding;
        if (pop)          outstanding_nxt = 1'b1;
        else if (done_ok) outstanding_nxt = 1'b0;

        read_cnt_nxt = read_cnt;
        if (read_push && !read_done)      read_cnt_nxt = read_cnt + RCW'(1);
        else if (read_done && !read_push) read_cnt_nxt = read_cnt - RCW'(1);

        valid_nxt = (level_nxt != '0) && !outstanding_nxt;
`ifdef POSTED_WRITE_EN
        busy_nxt = (level_nxt == LW'(DEPTH)) || (read_cnt_nxt != '0);
`else
        busy_nxt = (level_nxt != '0) || outstanding_nxt || commit;
`endif
    end

    always_ff @(posedge c200m) begin
        if (rst) begin
            op_valid_q  <= 1'b0;
            op_q        <= TXN_IDLE;
            outstanding <= 1'b0;
            inflight_rw <= 1'b0;
            read_cnt    <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            txn_busy    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            op_valid_q  <= valid_nxt;
            op_q        <= valid_nxt ? head_next : TXN_IDLE;
            outstanding <= outstanding_nxt;
            read_cnt    <= read_cnt_nxt;
            txn_busy    <= busy_nxt;
            if (pop) inflight_rw <= op_q.rw;
            if (read_done) rd_data <= op.op_rdata;
            if (commit && new_txn.rw) rd_valid <= 1'b0;
            else if (read_done)       rd_valid <= 1'b1;
            if (commit && full && !pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pistorm_txn_queue.sv
// Directed self-checking bench for pistorm_txn_queue; expected busy values
// follow whichever POSTED_WRITE_EN build is compiled.
module tb_pistorm_txn_queue;
    import pistorm_pkg::*;

`ifdef POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        c200m;
    logic        rst;
    logic        pi_wr_stb;
    logic [1:0]  pi_reg;
    logic [15:0] pi_wdata;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        txn_busy;
    logic        overflow;
    logic [2:0]  level;
    int checks   = 0;
    int failures = 0;

    pistorm_txn_queue_if #(.AW(24), .DW(16)) bus ();

    pistorm_txn_queue #(.DEPTH(4), .AW(24), .DW(16)) dut (
        .c200m     (c200m),
        .rst       (rst),
        .pi_wr_stb (pi_wr_stb),
        .pi_reg    (pi_reg),
        .pi_wdata  (pi_wdata),
        .op        (bus),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .txn_busy  (txn_busy),
        .overflow  (overflow),
        .level     (level)
    );

    initial c200m = 1'b0;
    always #5 c200m = ~c200m;

    task automatic cycle();
        @(posedge c200m);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] r, input logic [15:0] d);
        pi_wr_stb = 1'b1;
        pi_reg    = r;
        pi_wdata  = d;
        cycle();
        pi_wr_stb = 1'b0;
    endtask

    task automatic commit_txn(input logic [15:0] data, input logic [15:0] lo, input logic [15:0] hi);
        reg_write(REG_DATA, data);
        reg_write(REG_ADDR_LO, lo);
        reg_write(REG_ADDR_HI, hi);
    endtask

    task automatic launch();
        bus.op_ready = 1'b1;
        cycle();
        bus.op_ready = 1'b0;
    endtask

    task automatic complete(input logic [15:0] rdata);
        bus.op_done  = 1'b1;
        bus.op_rdata = rdata;
        cycle();
        bus.op_done  = 1'b0;
        bus.op_rdata = 16'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_op_valid got %0h want 0", bus.op_valid); end
        checks++; if (bus.op_uds_n !== 1'b1) begin failures++; $display("[TB] FAIL rst_uds_n got %0h want 1", bus.op_uds_n); end
        checks++; if (bus.op_lds_n !== 1'b1) begin failures++; $display("[TB] FAIL rst_lds_n got %0h want 1", bus.op_lds_n); end
        checks++; if (bus.op_addr !== 24'h0) begin failures++; $display("[TB] FAIL rst_addr got %0h want 0", bus.op_addr); end
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL rst_level got %0d want 0", level); end
        checks++; if (txn_busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got %0h want 0", txn_busy); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL rst_overflow got %0h want 0", overflow); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_rd_valid got %0h want 0", rd_valid); end
    endtask

    task automatic test_word_write();
        commit_txn(16'hBEEF, 16'h1234, 16'h0000);
        checks++; if (bus.op_valid !== 1'b1) begin failures++; $display("[TB] FAIL word_valid got %0h want 1", bus.op_valid); end
        checks++; if (bus.op_addr !== 24'h001234) begin failures++; $display("[TB] FAIL word_addr got %0h want 001234", bus.op_addr); end
        checks++; if (bus.op_data !== 16'hBEEF) begin failures++; $display("[TB] FAIL word_data got %0h want beef", bus.op_data); end
        checks++; if ({bus.op_rw, bus.op_uds_n, bus.op_lds_n} !== 3'b000) begin failures++; $display("[TB] FAIL word_ctrl got %b want 000", {bus.op_rw, bus.op_uds_n, bus.op_lds_n}); end
        checks++; if (level !== 3'd1) begin failures++; $display("[TB] FAIL word_level got %0d want 1", level); end
        checks++; if (txn_busy !== !POSTED) begin failures++; $display("[TB] FAIL word_busy got %0h want %0h", txn_busy, !POSTED); end
        launch();
        checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("[TB] FAIL word_inflight_valid got %0h want 0", bus.op_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL word_inflight_level got %0d want 0", level); end
        checks++; if (txn_busy !== !POSTED) begin failures++; $display("[TB] FAIL word_inflight_busy got %0h want %0h", txn_busy, !POSTED); end
        complete(16'h0);
        checks++; if (txn_busy !== 1'b0) begin failures++; $display("[TB] FAIL word_done_busy got %0h want 0", txn_busy); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL word_done_rd_valid got %0h want 0", rd_valid); end
    endtask

    task automatic test_byte_read();
        reg_write(REG_ADDR_LO, 16'h0001);
        reg_write(REG_ADDR_HI, 16'h0300);
        checks++; if (bus.op_addr !== 24'h000001) begin failures++; $display("[TB] FAIL bread_addr got %0h want 000001", bus.op_addr); end
        checks++; if ({bus.op_rw, bus.op_uds_n, bus.op_lds_n} !== 3'b110) begin failures++; $display("[TB] FAIL bread_ctrl got %b want 110", {bus.op_rw, bus.op_uds_n, bus.op_lds_n}); end
        checks++; if (txn_busy !== 1'b1) begin failures++; $display("[TB] FAIL bread_busy got %0h want 1", txn_busy); end
        launch();
        checks++; if (txn_busy !== 1'b1) begin failures++; $display("[TB] FAIL bread_inflight_busy got %0h want 1", txn_busy); end
        complete(16'h00A5);
        checks++; if (rd_data !== 16'h00A5) begin failures++; $display("[TB] FAIL bread_rd_data got %0h want 00a5", rd_data); end
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL bread_rd_valid got %0h want 1", rd_valid); end
        checks++; if (txn_busy !== 1'b0) begin failures++; $display("[TB] FAIL bread_done_busy got %0h want 0", txn_busy); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) commit_txn(16'h1000 + 16'(i), 16'h0100 + 16'(i), 16'h0000);
        checks++; if (level !== 3'd4) begin failures++; $display("[TB] FAIL ovf_level got %0d want 4", level); end
        checks++; if (txn_busy !== 1'b1) begin failures++; $display("[TB] FAIL ovf_busy got %0h want 1", txn_busy); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag got %0h want 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.op_valid !== 1'b1) begin failures++; $display("[TB] FAIL ovf_valid_%0d got %0h want 1", i, bus.op_valid); end
            checks++; if (bus.op_addr !== 24'h000100 + 24'(i)) begin failures++; $display("[TB] FAIL ovf_addr_%0d got %0h want %0h", i, bus.op_addr, 24'h000100 + 24'(i)); end
            checks++; if (bus.op_data !== 16'h1000 + 16'(i)) begin failures++; $display("[TB] FAIL ovf_data_%0d got %0h want %0h", i, bus.op_data, 16'h1000 + 16'(i)); end
            launch();
            checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_hold_%0d got %0h want 0", i, bus.op_valid); end
            complete(16'h0);
        end
        checks++; if (bus.op_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_drained_valid got %0h want 0", bus.op_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL ovf_drained_level got %0d want 0", level); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky got %0h want 1", overflow); end
    endtask

    task automatic test_read_behind_writes();
        do_reset();
        for (int i = 0; i < 3; i++) commit_txn(16'h2000 + 16'(i), 16'h0200 + 16'(i), 16'h0000);
        reg_write(REG_ADDR_LO, 16'h0010);
        reg_write(REG_ADDR_HI, 16'h0200);
        for (int i = 0; i < 3; i++) begin
            checks++; if (txn_busy !== 1'b1) begin failures++; $display("[TB] FAIL rbw_busy_pre_%0d got %0h want 1", i, txn_busy); end
            checks++; if (bus.op_addr !== 24'h000200 + 24'(i)) begin failures++; $display("[TB] FAIL rbw_addr_%0d got %0h want %0h", i, bus.op_addr, 24'h000200 + 24'(i)); end
            checks++; if (bus.op_rw !== 1'b0) begin failures++; $display("[TB] FAIL rbw_rw_%0d got %0h want 0", i, bus.op_rw); end
            launch();
            complete(16'hFFFF);
            checks++; if (txn_busy !== 1'b1) begin failures++; $display("[TB] FAIL rbw_busy_post_%0d got %0h want 1", i, txn_busy); end
            checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL rbw_rd_valid_%0d got %0h want 0", i, rd_valid); end
        end
        checks++; if ({bus.op_valid, bus.op_rw} !== 2'b11) begin failures++; $display("[TB] FAIL rbw_read_head got %b want 11", {bus.op_valid, bus.op_rw}); end
        checks++; if (bus.op_addr !== 24'h000010) begin failures++; $display("[TB] FAIL rbw_read_addr got %0h want 000010", bus.op_addr); end
        launch();
        checks++; if (txn_busy !== 1'b1) begin failures++; $display("[TB] FAIL rbw_read_busy got %0h want 1", txn_busy); end
        complete(16'h5A5A);
        checks++; if (rd_data !== 16'h5A5A) begin failures++; $display("[TB] FAIL rbw_rd_data got %0h want 5a5a", rd_data); end
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL rbw_rd_valid got %0h want 1", rd_valid); end
        checks++; if (txn_busy !== 1'b0) begin failures++; $display("[TB] FAIL rbw_done_busy got %0h want 0", txn_busy); end
    endtask

    task automatic test_full_pop_commit();
        do_reset();
        for (int i = 0; i < 4; i++) commit_txn(16'h3000 + 16'(i), 16'h0300 + 16'(i), 16'h0000);
        reg_write(REG_DATA, 16'h3004);
        reg_write(REG_ADDR_LO, 16'h0304);
        bus.op_ready = 1'b1;
        reg_write(REG_ADDR_HI, 16'h0000);
        bus.op_ready = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL fpc_overflow got %0h want 0", overflow); end
        checks++; if (level !== 3'd4) begin failures++; $display("[TB] FAIL fpc_level got %0d want 4", level); end
        checks++; if (txn_busy !== 1'b1) begin failures++; $display("[TB] FAIL fpc_busy got %0h want 1", txn_busy); end
        complete(16'h0);
        for (int i = 1; i < 5; i++) begin
            checks++; if (bus.op_addr !== 24'h000300 + 24'(i)) begin failures++; $display("[TB] FAIL fpc_addr_%0d got %0h want %0h", i, bus.op_addr, 24'h000300 + 24'(i)); end
            launch();
            complete(16'h0);
        end
    endtask

    task automatic test_reset_mid_txn();
        do_reset();
        reg_write(REG_ADDR_LO, 16'h0020);
        reg_write(REG_ADDR_HI, 16'h0200);
        launch();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        complete(16'h1234);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL rmid_rd_valid got %0h want 0", rd_valid); end
        checks++; if (rd_data !== 16'h0) begin failures++; $display("[TB] FAIL rmid_rd_data got %0h want 0", rd_data); end
        checks++; if (txn_busy !== 1'b0) begin failures++; $display("[TB] FAIL rmid_busy got %0h want 0", txn_busy); end
        checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL rmid_level got %0d want 0", level); end
        checks++; if ({bus.op_valid, bus.op_uds_n, bus.op_lds_n} !== 3'b011) begin failures++; $display("[TB] FAIL rmid_op got %b want 011", {bus.op_valid, bus.op_uds_n, bus.op_lds_n}); end
        commit_txn(16'h4444, 16'h0040, 16'h0000);
        checks++; if (bus.op_valid !== 1'b1) begin failures++; $display("[TB] FAIL rmid_relaunch got %0h want 1", bus.op_valid); end
        launch();
        complete(16'h0);
    endtask

    task automatic test_done_with_read_commit();
        do_reset();
        reg_write(REG_ADDR_LO, 16'h0050);
        reg_write(REG_ADDR_HI, 16'h0200);
        launch();
        reg_write(REG_ADDR_LO, 16'h0052);
        bus.op_done  = 1'b1;
        bus.op_rdata = 16'h1111;
        reg_write(REG_ADDR_HI, 16'h0200);
        bus.op_done  = 1'b0;
        checks++; if (txn_busy !== 1'b1) begin failures++; $display("[TB] FAIL dwr_busy got %0h want 1", txn_busy); end
        checks++; if (rd_data !== 16'h1111) begin failures++; $display("[TB] FAIL dwr_rd_data got %0h want 1111", rd_data); end
        checks++; if (bus.op_addr !== 24'h000052) begin failures++; $display("[TB] FAIL dwr_addr got %0h want 000052", bus.op_addr); end
        launch();
        complete(16'h2222);
        checks++; if (txn_busy !== 1'b0) begin failures++; $display("[TB] FAIL dwr_done_busy got %0h want 0", txn_busy); end
        checks++; if ({rd_valid, rd_data} !== {1'b1, 16'h2222}) begin failures++; $display("[TB] FAIL dwr_result got %0h want 12222", {rd_valid, rd_data}); end
    endtask

    initial begin
        rst          = 1'b1;
        pi_wr_stb    = 1'b0;
        pi_reg       = 2'd0;
        pi_wdata     = 16'h0;
        bus.op_ready = 1'b0;
        bus.op_done  = 1'b0;
        bus.op_rdata = 16'h0;
        test_reset();
        test_word_write();
        test_byte_read();
        test_overflow();
        test_read_behind_writes();
        test_full_pop_commit();
        test_reset_mid_txn();
        test_done_with_read_commit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pistorm_txn_queue.md
Name: pistorm_txn_queue

Overview:
- Pi-side transaction assembler and posted-write queue in the c200m domain.
- Sits between the Pi GPIO register decode and the 68K bus-cycle state machine.
- Builds complete bus requests from DATA/ADDR_LO/ADDR_HI register writes, queues them in order, and hands them one at a time to the bus engine over a valid/ready handshake.
- Captures read data returned by the engine and generates the busy indication driven onto PI_TXN_IN_PROGRESS.

Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- AW, 24: 68K address width.
- DW, 16: data width.

Ports:
- c200m  in  1  PI_CLK-derived core clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- pi_wr_stb  in  1  one-cycle pulse: synchronised rising edge of PI_WR.
- pi_reg  in  2  PI_A register select, valid with pi_wr_stb (0 DATA, 1 ADDR_LO, 2 ADDR_HI, 3 STATUS).
- pi_wdata  in  DW  PI_D, valid with pi_wr_stb.
- op_valid  out  1  head entry offered to the bus engine.
- op_ready  in  1  bus engine accepts the head entry (S0 launch).
- op_addr  out  AW  head address.
- op_data  out  DW  head write data.
- op_rw  out  1  1 = read.
- op_uds_n  out  1  head upper-byte strobe.
- op_lds_n  out  1  head lower-byte strobe.
- op_done  in  1  one-cycle pulse at end of bus cycle (S7).
- op_rdata  in  DW  read data, valid with op_done.
- rd_data  out  DW  last read result.
- rd_valid  out  1  rd_data holds the result of the most recent read.
- txn_busy  out  1  drives PI_TXN_IN_PROGRESS.
- overflow  out  1  sticky: a commit was dropped.
- level  out  clog2(DEPTH)+1  queued entry count, excluding the in-flight entry.

Behaviour:
- Reset values: every output 0, except op_uds_n = 1 and op_lds_n = 1. All staging registers, pointers, the outstanding flag and the pending flag are cleared.
- Register writes (on pi_wr_stb):
  - DATA: data_stage <= pi_wdata.
  - ADDR_LO: addr_lo <= pi_wdata; a0 <= pi_wdata[0].
  - ADDR_HI: commit.
  - STATUS: ignored by this block.
- Commit entry contents:
  - addr = {pi_wdata[7:0], addr_lo}; data = data_stage; rw = pi_wdata[9].
  - pi_wdata[8] = 1 (byte): uds_n = a0, lds_n = !a0.
  - pi_wdata[8] = 0 (word): uds_n = lds_n = 0.
- Queue:
  - In-order FIFO.
  - Commit while full with no pop in the same cycle: entry dropped, overflow <= 1. overflow clears only on rst.
  - Simultaneous pop and commit while full: accepted.
- Launch:
  - op_valid = !empty && !outstanding; at most one transaction in flight.
  - op_valid && op_ready pops the head and sets outstanding.
  - op_* outputs are registered copies of the head and stay stable while op_valid is high.
- Latency: commit in cycle N into an empty, idle queue gives op_valid in cycle N+1.
- Completion:
  - op_done clears outstanding.
  - If the in-flight entry is a read: rd_data <= op_rdata, rd_valid <= 1.
  - op_done while not outstanding is ignored.
- rd_valid clears on any subsequent commit of a read.
- read_pending:
  - Set on commit of a read; cleared on that read's op_done.
  - A read committed behind queued writes stays pending until the writes drain and the read completes.
- txn_busy is registered and equals (full || read_pending), evaluated on the next-state values.
- Same-cycle op_done and read commit: pending stays set for the new read.
- rst mid-transaction: the queue is flushed and the in-flight op_done is ignored.

Optional Feature:
- Macro: POSTED_WRITE_EN.
- Defined: writes are posted as described; txn_busy = full || read_pending.
- Undefined (legacy, fully synchronous):
  - txn_busy = !empty || outstanding || (commit this cycle).
  - The Pi must see every write complete before issuing the next.
  - The queue logic remains; with that protocol level never exceeds 1.

Decomposition:
- Shared package pistorm_pkg holds:
  - REG_DATA / REG_ADDR_LO / REG_ADDR_HI / REG_STATUS constants.
  - Size/rw bit positions (8, 9).
  - A txn_t struct {addr[23:0], data[15:0], rw, uds_n, lds_n}.
- One natural sub-module: pistorm_sync_fifo, a generic DEPTH x txn_t FIFO with push, pop, full, empty and level. Assembly, handshake and busy logic stay in the top module.

Test Plan:
- Word write: DATA=0xBEEF, ADDR_LO=0x1234, ADDR_HI=0x0000 → next cycle op_valid with addr 0x001234, data 0xBEEF, rw 0, uds_n 0, lds_n 0; txn_busy stays 0 (POSTED_WRITE_EN).
- Byte read: ADDR_LO=0x0001, ADDR_HI=0x0300 → uds_n 1, lds_n 0, rw 1, txn_busy 1. op_done with op_rdata 0x00A5 → rd_data 0x00A5, rd_valid 1, txn_busy 0 the cycle after.
- Overflow: hold op_ready=0, commit 5 writes → level 4, txn_busy 1, overflow 1; only the first 4 are launched, in order, once op_ready rises.
- Read behind 3 posted writes: read completes only after 3 write op_done pulses; txn_busy stays 1 throughout.
- Full queue: pop and commit in the same cycle → no overflow, level stays 4.
- Reset after launch: assert rst with outstanding set, then pulse op_done → no rd_valid, level 0, all outputs at reset values.
